// File: rtl/sdm_mod.sv
// sdm_mod: streaming first-order sigma-delta density modulator.
// Each signed 4-bit sample (-8..7) becomes one 16-bit serial frame carrying
// exactly (sample + 8) ones, spread evenly by a 4-bit phase accumulator.
// Ports:
//   rstn      async active-low reset        fclk      clock (posedge)
//   clear     synchronous flush/abort        enable    streaming enable
//   div       bit period = div+1 cycles      push      write wdata into FIFO
//   wdata     signed sample                  full/empty FIFO status
//   overflow  sticky: push dropped (full)    underrun  sticky: midscale substituted
//   st        00 IDLE, 01 RUN, 10 STOP       frame     high during bit 0 of a frame
//   tx        serial density bit
module sdm_mod #(
    parameter int unsigned AW = 2,
    parameter int unsigned DW = 4
) (
    input  logic          rstn,
    input  logic          fclk,
    input  logic          clear,
    input  logic          enable,
    input  logic [DW-1:0] div,
    input  logic          push,
    input  logic [3:0]    wdata,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic          underrun,
    output logic [1:0]    st,
    output logic          frame,
    output logic          tx
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned CW    = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_STOP = 2'b10
    } state_t;

    logic [3:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, empty_q, overflow_q, underrun_q;
    state_t        state_q;
    logic [3:0]    acc_q, k_q, bitcnt_q;
    logic [DW-1:0] cnt_q, div_l_q;
    logic          tx_q, frame_q;

    logic          tick, last_bit, do_fetch, do_pop, do_push;
    logic [3:0]    fetch_k;
    logic [4:0]    sum;

    // Fetch/FIFO decisions and the accumulator adder.
    always_comb begin
        tick     = (cnt_q == div_l_q);
        last_bit = (bitcnt_q == 4'd15);
        do_fetch = 1'b0;
        if (!clear) begin
            if (state_q == S_IDLE) do_fetch = enable && !empty_q;
            else                   do_fetch = tick && last_bit && enable;
        end
        do_pop  = do_fetch && !empty_q;
        do_push = !clear && push && !full_q;
        // An empty FIFO at a frame boundary yields the midscale code.
        fetch_k = empty_q ? 4'b1000 : (mem_q[rd_ptr_q] ^ 4'b1000);
        sum     = {1'b0, acc_q} + {1'b0, k_q};
        count_d = count_q;
        if (clear) count_d = '0;
        else       count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    // FIFO storage; contents need no reset, occupancy is tracked separately.
    always_ff @(posedge fclk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    // FIFO pointers, flags, state and bit generator.
    always_ff @(posedge fclk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
            state_q    <= S_IDLE;
            acc_q      <= '0;
            k_q        <= '0;
            bitcnt_q   <= '0;
            cnt_q      <= '0;
            div_l_q    <= '0;
            tx_q       <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
            if (clear) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                overflow_q <= 1'b0;
                underrun_q <= 1'b0;
                state_q    <= S_IDLE;
                acc_q      <= '0;
                bitcnt_q   <= '0;
                cnt_q      <= '0;
                tx_q       <= 1'b0;
                frame_q    <= 1'b0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
                if (push && full_q) overflow_q <= 1'b1;
                if (do_fetch) begin
                    // acc restarts at 0; bit 0 is carry(0+k)=0, leaving acc=k.
                    if (empty_q) underrun_q <= 1'b1;
                    k_q      <= fetch_k;
                    acc_q    <= fetch_k;
                    cnt_q    <= '0;
                    bitcnt_q <= '0;
                    div_l_q  <= div;
                    tx_q     <= 1'b0;
                    frame_q  <= 1'b1;
                    state_q  <= S_RUN;
                end else begin
                    case (state_q)
                        S_RUN, S_STOP: begin
                            if (tick) begin
                                cnt_q <= '0;
                                if (last_bit) begin
                                    // Boundary without enable: stream ends.
                                    state_q <= S_IDLE;
                                    tx_q    <= 1'b0;
                                    frame_q <= 1'b0;
                                end else begin
                                    bitcnt_q <= bitcnt_q + 4'd1;
                                    tx_q     <= sum[4];
                                    acc_q    <= sum[3:0];
                                    frame_q  <= 1'b0;
                                    state_q  <= enable ? S_RUN : S_STOP;
                                end
                            end else begin
                                cnt_q   <= cnt_q + DW'(1);
                                state_q <= enable ? S_RUN : S_STOP;
                            end
                        end
                        default: begin
                            state_q <= S_IDLE;
                            tx_q    <= 1'b0;
                            frame_q <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign overflow = overflow_q;
    assign underrun = underrun_q;
    assign st       = state_q;
    assign frame    = frame_q;
    assign tx       = tx_q;

endmodule

// File: tb/tb_sdm_mod.sv
// Testbench for sdm_mod: scoreboard of expected frames (sample, divider,
// abort flag) filled by the stimulus, drained by an independent monitor that
// rebuilds each frame's bit pattern from floor((i+1)k/16) - floor(ik/16).
module tb_sdm_mod;

    logic       rstn, fclk, clear, enable, push;
    logic [3:0] div, wdata;
    logic       full, empty, overflow, underrun, frame, tx;
    logic [1:0] st;

    typedef struct {
        int sample;
        int d;
        bit aborted;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    sdm_mod #(.AW(2), .DW(4)) dut (
        .rstn(rstn), .fclk(fclk), .clear(clear), .enable(enable), .div(div),
        .push(push), .wdata(wdata), .full(full), .empty(empty),
        .overflow(overflow), .underrun(underrun), .st(st), .frame(frame), .tx(tx)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    function automatic void chk(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endfunction

    function automatic exp_t mk(input int s, input int d, input bit ab);
        exp_t e;
        e.sample  = s;
        e.d       = d;
        e.aborted = ab;
        return e;
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge fclk);
            #1;
        end
    endtask

    task automatic push1(input int s, input bit track, input int d, input bit ab);
        push  = 1'b1;
        wdata = 4'(s);
        cyc(1);
        push  = 1'b0;
        if (track) exp_q.push_back(mk(s, d, ab));
    endtask

    function automatic int rnd_sample();
        return int'($urandom_range(15, 0)) - 8;
    endfunction

    // Flow-controlled stream of n samples, then a clean stop before the FIFO runs dry.
    task automatic stream(input int n, input int d, input bit sweep);
        int perm[16];
        int idx, guard, s, tmp, j;
        for (int i = 0; i < 16; i++) perm[i] = i - 8;
        for (int i = 15; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        div    = 4'(d);
        enable = 1'b1;
        idx    = 0;
        guard  = 0;
        while (idx < n && guard < 5000) begin
            if (!full) begin
                s     = sweep ? perm[idx] : rnd_sample();
                push  = 1'b1;
                wdata = 4'(s);
                exp_q.push_back(mk(s, d, 1'b0));
                idx++;
            end else begin
                push = 1'b0;
            end
            cyc(1);
            guard++;
        end
        push  = 1'b0;
        guard = 0;
        while (!empty && guard < 2000) begin cyc(1); guard++; end
        chk("stream_drain_empty", int'(empty), 1);
        enable = 1'b0;
        guard  = 0;
        while (st != 2'b00 && guard < 2000) begin cyc(1); guard++; end
        chk("stream_end_st", int'(st), 0);
        chk("stream_end_tx", int'(tx), 0);
    endtask

    // Monitor: pops one expectation per observed frame start and checks it bit by bit.
    initial begin : monitor
        exp_t it;
        int   nb, ones, k, b, expb;
        bit   aborted_seen;
        forever begin
            @(negedge fclk);
            if (rstn && frame) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_frame: got a frame start, expected none (t=%0t)", $time);
                end else begin
                    it           = exp_q.pop_front();
                    nb           = 16 * (it.d + 1);
                    k            = it.sample + 8;
                    ones         = 0;
                    aborted_seen = 1'b0;
                    for (int c = 0; c < nb; c++) begin
                        if (c > 0) @(negedge fclk);
                        if (it.aborted && (!rstn || st == 2'b00)) begin
                            aborted_seen = 1'b1;
                            break;
                        end
                        b    = c / (it.d + 1);
                        expb = ((b + 1) * k) / 16 - (b * k) / 16;
                        chk("tx_bit", int'(tx), expb);
                        chk("frame_flag", int'(frame), (c <= it.d) ? 1 : 0);
                        if (c % (it.d + 1) == 0) ones += int'(tx);
                    end
                    if (it.aborted) chk("abort_seen", int'(aborted_seen), 1);
                    else            chk("decoded_sample", ones - 8, it.sample);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int s1, s2, s3, guard;
        rstn   = 1'b1;
        clear  = 1'b0;
        enable = 1'b0;
        push   = 1'b0;
        div    = 4'd0;
        wdata  = 4'd0;
        #2 rstn = 1'b0;
        #2;
        chk("rst_tx", int'(tx), 0);
        chk("rst_frame", int'(frame), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_underrun", int'(underrun), 0);
        chk("rst_st", int'(st), 0);
        cyc(2);
        rstn = 1'b1;
        cyc(1);

        // Two samples back to back, then enable drops in the second frame.
        div = 4'd0;
        push1(3, 1'b1, 0, 1'b0);
        push1(-8, 1'b1, 0, 1'b0);
        enable = 1'b1;
        cyc(1);
        chk("a_first_st", int'(st), 1);
        chk("a_first_frame", int'(frame), 1);
        chk("a_first_tx", int'(tx), 0);
        cyc(16);
        chk("a_gapless_frame", int'(frame), 1);
        chk("a_gapless_st", int'(st), 1);
        cyc(5);
        enable = 1'b0;
        cyc(2);
        chk("a_stop_st", int'(st), 2);
        cyc(12);
        chk("a_idle_st", int'(st), 0);
        chk("a_idle_tx", int'(tx), 0);
        chk("a_idle_empty", int'(empty), 1);

        // Full code sweep at div=3, then a random stream at a random divider.
        stream(16, 3, 1'b1);
        stream(10, int'($urandom_range(2, 0)), 1'b0);

        // Overflow with enable low.
        for (int i = 0; i < 5; i++) begin
            push1(rnd_sample(), 1'b0, 0, 1'b0);
            chk("c_full", int'(full), (i >= 3) ? 1 : 0);
            chk("c_overflow", int'(overflow), (i == 4) ? 1 : 0);
        end
        cyc(5);
        chk("c_overflow_sticky", int'(overflow), 1);
        clear = 1'b1;
        push  = 1'b1;
        wdata = 4'd5;
        cyc(1);
        clear = 1'b0;
        push  = 1'b0;
        chk("c_clear_empty", int'(empty), 1);
        chk("c_clear_full", int'(full), 0);
        chk("c_clear_overflow", int'(overflow), 0);
        cyc(1);
        chk("c_push_dropped", int'(empty), 1);

        // FIFO runs dry: midscale frame with underrun, then real data resumes.
        div = 4'd0;
        s1  = rnd_sample();
        s2  = rnd_sample();
        push1(s1, 1'b1, 0, 1'b0);
        exp_q.push_back(mk(0, 0, 1'b0));
        enable = 1'b1;
        cyc(1);
        chk("d_no_underrun_yet", int'(underrun), 0);
        cyc(18);
        chk("d_underrun_set", int'(underrun), 1);
        push1(s2, 1'b1, 0, 1'b0);
        cyc(20);
        enable = 1'b0;
        cyc(12);
        chk("d_idle_st", int'(st), 0);
        chk("d_idle_tx", int'(tx), 0);

        // Enable drops during bit 7; frame completes, FIFO keeps its entry.
        div = 4'd1;
        s1  = rnd_sample();
        s2  = rnd_sample();
        push1(s1, 1'b1, 1, 1'b0);
        push1(s2, 1'b0, 1, 1'b0);
        enable = 1'b1;
        cyc(1);
        cyc(14);
        enable = 1'b0;
        cyc(2);
        chk("e_stop_st", int'(st), 2);
        cyc(18);
        chk("e_idle_st", int'(st), 0);
        chk("e_idle_tx", int'(tx), 0);
        chk("e_fifo_kept", int'(empty), 0);

        // Clear mid-frame.
        div = 4'd0;
        exp_q.push_back(mk(s2, 0, 1'b1));
        chk("f_underrun_before", int'(underrun), 1);
        enable = 1'b1;
        cyc(1);
        cyc(5);
        clear = 1'b1;
        cyc(1);
        clear  = 1'b0;
        enable = 1'b0;
        chk("f_tx", int'(tx), 0);
        chk("f_st", int'(st), 0);
        chk("f_frame", int'(frame), 0);
        chk("f_empty", int'(empty), 1);
        chk("f_overflow", int'(overflow), 0);
        chk("f_underrun", int'(underrun), 0);
        cyc(3);

        // Asynchronous reset mid-frame.
        div = 4'd2;
        s3  = rnd_sample();
        push1(s3, 1'b1, 2, 1'b1);
        push1(rnd_sample(), 1'b0, 2, 1'b0);
        enable = 1'b1;
        cyc(1);
        cyc(10);
        rstn = 1'b0;
        #1;
        chk("g_tx", int'(tx), 0);
        chk("g_st", int'(st), 0);
        chk("g_frame", int'(frame), 0);
        chk("g_empty", int'(empty), 1);
        chk("g_full", int'(full), 0);
        cyc(2);
        rstn   = 1'b1;
        enable = 1'b0;
        cyc(2);
        chk("g_after_empty", int'(empty), 1);
        chk("g_after_st", int'(st), 0);

        guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin cyc(1); guard++; end
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
